// File: rtl/dm_dump_pkg.sv
// Shared constants, FSM state type and small helpers for the data-memory UART dump.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dm_dump_pkg;

  localparam int DM_ADDR_W  = 4;
  localparam int DM_DATA_W  = 8;
  localparam int DM_DEPTH   = 16;
  localparam int FRAME_BITS = 10;

  // One start bit and one stop bit frame the data bits.
  localparam int DATA_BITS = FRAME_BITS - 2;

  // Wide enough for the largest legal CLKS_PER_BIT (65535).
  localparam int BAUD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  // True when the address is the last word of the memory.
  function automatic logic is_last_addr(input logic [DM_ADDR_W-1:0] addr);
    return addr == DM_ADDR_W'(DM_DEPTH - 1);
  endfunction

endpackage

// File: rtl/dm_dump_tx_baud_gen.sv
// Bit-period counter: tick marks the last cycle of each CLKS_PER_BIT-cycle bit.
// Latency: tick is combinational from the counter; clear takes effect next cycle.
// Backpressure: none; counts only while enable is high, clear wins over counting.
module baud_gen
  import dm_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [BAUD_W-1:0] CNT_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;

  // Tick on the final cycle of the bit period.
  always_comb begin
    tick = enable && (cnt_q == CNT_MAX);
  end

  // Count 0..CNT_MAX, wrapping on tick; clear restarts the period at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + BAUD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_dump_tx.sv
// Dumps all 16 data-memory bytes over an 8N1 UART line after a halt request.
// Latency: 16*(1+10*CLKS_PER_BIT)+1 cycles start-accept to done (x20 with DUMP_ADDR_HEADER_EN).
// Backpressure: none; start is only sampled in IDLE. DUMP_ADDR_HEADER_EN adds an address header frame.
module dm_dump_tx
  import dm_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [DM_ADDR_W-1:0] dm_addr,
  input  logic [DM_DATA_W-1:0] dm_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_q,  state_d;
  logic [DM_ADDR_W-1:0] addr_q,   addr_d;
  logic [DM_DATA_W-1:0] shift_q,  shift_d;
  logic [2:0]           bit_q,    bit_d;
`ifdef DUMP_ADDR_HEADER_EN
  logic [DM_DATA_W-1:0] data_q,   data_d;
  logic                 second_q, second_d;
`endif

  logic baud_clear;
  logic baud_en;
  logic baud_tick;

  // Bit timing only runs while a frame is on the line; every state entry restarts it.
  always_comb begin
    baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    baud_clear = (state_d != state_q);
  end

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .enable(baud_en),
    .tick  (baud_tick)
  );

  // Outputs decoded straight from state so reset forces tx high without a clock.
  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
    dm_addr = addr_q;
  end

  // Next-state logic: sequence LOAD -> START -> DATA x8 -> STOP per byte over all addresses.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
`ifdef DUMP_ADDR_HEADER_EN
    data_d   = data_q;
    second_d = second_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The byte is captured here only, so later read-port changes cannot disturb it.
`ifdef DUMP_ADDR_HEADER_EN
        shift_d  = {4'h0, addr_q};
        data_d   = dm_data;
        second_d = 1'b0;
`else
        shift_d  = dm_data;
`endif
        state_d = START;
      end
      START: begin
        if (baud_tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
`ifdef DUMP_ADDR_HEADER_EN
          if (!second_q) begin
            // Header frame finished: send the held data byte without re-reading memory.
            shift_d  = data_q;
            second_d = 1'b1;
            state_d  = START;
          end else if (is_last_addr(addr_q)) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 4'd1;
            state_d = LOAD;
          end
`else
          if (is_last_addr(addr_q)) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 4'd1;
            state_d = LOAD;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
`ifdef DUMP_ADDR_HEADER_EN
      data_q   <= '0;
      second_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
`ifdef DUMP_ADDR_HEADER_EN
      data_q   <= data_d;
      second_q <= second_d;
`endif
    end
  end

endmodule

// File: tb/tb_dm_dump_tx.sv
// Directed bench for dm_dump_tx with CLKS_PER_BIT=4 and a behavioural read-port memory.
// Latency: frames decoded mid-bit on the falling edge; dump length checked against the closed form.
// Backpressure: none; start is driven as pulses or held high.
module tb_dm_dump_tx;

  localparam int CPB = 4;
`ifdef DUMP_ADDR_HEADER_EN
  localparam int DUMP_LEN = 16 * (1 + 20 * CPB) + 1;
`else
  localparam int DUMP_LEN = 16 * (1 + 10 * CPB) + 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dm_addr;
  logic [7:0] dm_data;
  logic       tx;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  dm_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dm_addr(dm_addr),
    .dm_data(dm_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  // Behavioural memory; optionally corrupts address 2 from the cycle after its LOAD.
  logic [7:0] mem [16];
  logic       corrupt_en = 1'b0;
  int         hold_cnt = 0;

  always @(posedge clk) hold_cnt <= (dm_addr == 4'd2) ? hold_cnt + 1 : 0;
  assign dm_data = (corrupt_en && dm_addr == 4'd2 && hold_cnt != 0) ? 8'hFF : mem[dm_addr];

  // Cycle bookkeeping for dump length and done-pulse counting.
  int   cyc = 0;
  int   rise_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy === 1'b1 && busy_prev === 1'b0) rise_cyc <= cyc;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  typedef struct {
    logic [3:0] addr;
    logic [7:0] mem_val;
    logic [7:0] exp_byte;
    logic [7:0] exp_hdr;
  } vec_t;

  vec_t vecs [32];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Decode one 8N1 frame, sampling each bit two cycles into its period.
  task automatic rx_frame(output logic [7:0] b, output logic [3:0] a, output bit ok);
    int n = 0;
    ok = 1'b1;
    b  = '0;
    a  = dm_addr;
    while (tx !== 1'b0 && n < 25 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    a = dm_addr;
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic recv_entry(input int idx);
    logic [7:0] b;
    logic [3:0] a;
    bit         ok;
`ifdef DUMP_ADDR_HEADER_EN
    rx_frame(b, a, ok);
    chk($sformatf("hdr_frame_ok[%0d]", idx), 32'(ok), 32'd1);
    chk($sformatf("hdr_byte[%0d]", idx), 32'(b), 32'(vecs[idx].exp_hdr));
`endif
    rx_frame(b, a, ok);
    chk($sformatf("frame_ok[%0d]", idx), 32'(ok), 32'd1);
    chk($sformatf("data_byte[%0d]", idx), 32'(b), 32'(vecs[idx].exp_byte));
    chk($sformatf("frame_addr[%0d]", idx), 32'(a), 32'(vecs[idx].addr));
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic load_mem(input int base);
    for (int i = 0; i < 16; i++) mem[i] = vecs[base + i].mem_val;
  endtask

  // Full dump of one table section, checking every frame, done timing and single done pulse.
  task automatic run_dump(input int base, input bit poke_at_9);
    int d0;
    load_mem(base);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      recv_entry(base + i);
      if (poke_at_9 && i == 9) begin
        chk("busy_at_9", 32'(busy), 32'd1);
        pulse_start();
      end
    end
    wait_done(20 * CPB);
    @(negedge clk);
    chk("dump_len", 32'(done_cyc - rise_cyc + 1), 32'(DUMP_LEN));
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("tx_idle_high", 32'(tx), 32'd1);
  endtask

  initial begin
    int         d0;
    int         t1;
    int         n;
    logic [7:0] tbl_b [16];

    reset = 1'b1;
    start = 1'b0;

    // Section 0: byte i = A0+i. Section 1: hand-picked patterns (addr 2 = 3C, addr 7 = 5A).
    tbl_b = '{8'h00, 8'hFF, 8'h3C, 8'hAA, 8'h01, 8'h80, 8'h55, 8'h5A,
              8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hC3};
    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{4'(i), 8'hA0 + 8'(i), 8'hA0 + 8'(i), {4'h0, 4'(i)}};
      vecs[16 + i] = '{4'(i), tbl_b[i], tbl_b[i], {4'h0, 4'(i)}};
    end
    load_mem(0);

    // Reset values hold before any clock edge.
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Dump of A0..AF with a start pulse ignored mid-dump.
    run_dump(0, 1'b1);

    // Pattern dump with address 2 read data corrupted after its LOAD.
    corrupt_en = 1'b1;
    run_dump(16, 1'b0);
    corrupt_en = 1'b0;

    // Reset during data bit 3 of address 5 aborts the dump.
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (dm_addr !== 4'd5 && n < 20 * 41 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("reached_addr5", 32'(dm_addr), 32'd5);
    n = 0;
    while (tx !== 1'b0 && n < 25 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * CPB + 1) @(negedge clk);
    chk("tx_bit3_low", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(dm_addr), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    recv_entry(16);
    wait_done(DUMP_LEN + 20);
    @(negedge clk);
    chk("resume_len", 32'(done_cyc - rise_cyc + 1), 32'(DUMP_LEN));

    // Start held high: back-to-back dumps with a single idle cycle between them.
    repeat (2) @(negedge clk);
    start = 1'b1;
    wait_done(DUMP_LEN + 20);
    t1 = cyc;
    @(negedge clk);
    chk("gap_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("gap_restart_busy", 32'(busy), 32'd1);
    chk("gap_restart_addr", 32'(dm_addr), 32'd0);
    wait_done(DUMP_LEN + 20);
    chk("done_to_done", 32'(cyc - t1), 32'(DUMP_LEN + 1));
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_release_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
